// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the MIPS datapath (master) and the
// iterative multiply/divide unit (slave).
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start_in;
    logic [1:0]            op_in;
    logic [DATA_WIDTH-1:0] operand_a_in;
    logic [DATA_WIDTH-1:0] operand_b_in;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;
    logic                  busy_out;
    logic                  done_out;
    logic                  div_by_zero_out;

    modport master (
        output start_in, op_in, operand_a_in, operand_b_in,
        input  hi_out, lo_out, busy_out, done_out, div_by_zero_out
    );

    modport slave (
        input  start_in, op_in, operand_a_in, operand_b_in,
        output hi_out, lo_out, busy_out, done_out, div_by_zero_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-subtract
// step per clock on operand magnitudes, then a single sign-fixup cycle.
module mult_div_unit #(
    parameter int DATA_WIDTH = 16
) (
    input  logic           clock_in,
    input  logic           reset_n_in,
    mult_div_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0]   ONE_W  = 1;
    localparam logic [2*W-1:0] ONE_2W = 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_e;

    state_e         state_q, state_d;
    logic           is_div_q, is_div_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           dbz_q, dbz_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag, addend;
    logic [W:0]     mul_sum, div_rem, div_diff;
    logic           div_ge;
    logic [2*W-1:0] product, product_fix;
    logic [W-1:0]   quot_fix, rem_fix;

    // NOTE: combinational logic uses blocking '=' with every output defaulted
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        a_neg = bus.op_in[1] & bus.operand_a_in[W-1];
        b_neg = bus.op_in[1] & bus.operand_b_in[W-1];
        a_mag = a_neg ? (~bus.operand_a_in + ONE_W) : bus.operand_a_in;
        b_mag = b_neg ? (~bus.operand_b_in + ONE_W) : bus.operand_b_in;

        // {acc, shreg} is the product during MUL; acc=remainder, shreg=dividend/quotient during DIV
        addend   = shreg_q[0] ? opb_q : {W{1'b0}};
        mul_sum  = {1'b0, acc_q} + {1'b0, addend};
        div_rem  = {acc_q, shreg_q[W-1]};
        div_ge   = (div_rem >= {1'b0, opb_q});
        div_diff = div_rem - {1'b0, opb_q};

        product     = {acc_q, shreg_q};
        product_fix = neg_res_q ? (~product + ONE_2W) : product;
        quot_fix    = neg_res_q ? (~shreg_q + ONE_W) : shreg_q;
        rem_fix     = neg_rem_q ? (~acc_q + ONE_W) : acc_q;

        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        shreg_d   = shreg_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start_in) begin
                    if (bus.op_in[0] && (bus.operand_b_in == '0)) begin
                        hi_d    = bus.operand_a_in;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dbz_d     = 1'b0;
                        is_div_d  = bus.op_in[0];
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        acc_d     = '0;
                        shreg_d   = a_mag;
                        opb_d     = b_mag;
                        cnt_d     = '0;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    acc_d   = div_ge ? div_diff[W-1:0] : div_rem[W-1:0];
                    shreg_d = {shreg_q[W-2:0], div_ge};
                end else begin
                    acc_d   = mul_sum[W:1];
                    shreg_d = {mul_sum[0], shreg_q[W-1:1]};
                end
                if (cnt_q == CW'(W-1)) state_d = S_SIGN;
            end
            S_SIGN: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = product_fix;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset along with the control state so
    // an aborted operation can never leak partial values into HI/LO.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            shreg_q   <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            shreg_q   <= shreg_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.hi_out          = hi_q;
    assign bus.lo_out          = lo_q;
    assign bus.busy_out        = (state_q == S_CALC) || (state_q == S_SIGN);
    assign bus.done_out        = (state_q == S_DONE);
    assign bus.div_by_zero_out = dbz_q && (state_q == S_DONE);
endmodule
